// File: rtl/ibufds_rx_pkg.sv
// Shared types and pair encodings for the ibufds_rx_filter differential receiver.
// Pair values are written as {I, IB}.
package ibufds_rx_pkg;

  typedef enum logic {
    ST_STEADY = 1'b0,
    ST_QUAL   = 1'b1
  } chan_state_t;

  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;
  localparam logic [1:0] PAIR_LO   = 2'b00;
  localparam logic [1:0] PAIR_HI   = 2'b11;

  // Width of the qualification counter; bounds FILT_LEN to 1..255.
  localparam int QUAL_W = 8;

  // A pair is valid only when its two legs disagree (10 or 01).
  function automatic logic is_valid_pair(input logic [1:0] pair);
    return (pair == PAIR_ONE) || (pair == PAIR_ZERO);
  endfunction

endpackage

// File: rtl/ibufds_rx_chan.sv
// One receiver channel: two-flop synchroniser, stability filter, sticky data output,
// saturating invalid-event counter and, with IBUFDS_RX_EDGE_EN, rise/fall pulses.
module ibufds_rx_chan
  import ibufds_rx_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i,
  input  logic             ib,
  input  logic             cnt_clr,
  output logic             o,
  output logic             invalid,
  output logic [CNT_W-1:0] err_cnt
`ifdef IBUFDS_RX_EDGE_EN
  ,
  output logic             rise,
  output logic             fall
`endif
);

  localparam logic [QUAL_W-1:0] QUAL_TARGET = QUAL_W'(FILT_LEN);
  localparam logic [QUAL_W-1:0] QUAL_ONE    = QUAL_W'(1);

  logic [1:0]        sync1_q;
  logic [1:0]        sync2_q;
  logic [1:0]        sample;

  chan_state_t       state_q;
  chan_state_t       state_nxt;
  logic [1:0]        cp_q;
  logic [1:0]        cp_nxt;
  logic [1:0]        cand_q;
  logic [1:0]        cand_nxt;
  logic [QUAL_W-1:0] qual_q;
  logic [QUAL_W-1:0] qual_nxt;
  logic [QUAL_W-1:0] qual_inc;

  logic              commit;
  logic [1:0]        commit_pair;
  logic              o_nxt;
  logic              invalid_nxt;
  logic              err_event;
  logic [CNT_W-1:0]  cnt_nxt;

  // The pad pair is asynchronous to clk; both legs go through two flops before use.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {i, ib};
      sync2_q <= sync1_q;
    end
  end

  assign sample   = sync2_q;
  assign qual_inc = qual_q + QUAL_ONE;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt   = state_q;
    cand_nxt    = cand_q;
    qual_nxt    = qual_q;
    commit      = 1'b0;
    commit_pair = cand_q;

    case (state_q)
      ST_STEADY: begin
        if (sample != cp_q) begin
          if (FILT_LEN == 1) begin
            commit      = 1'b1;
            commit_pair = sample;
          end else begin
            cand_nxt  = sample;
            qual_nxt  = QUAL_ONE;
            state_nxt = ST_QUAL;
          end
        end
      end

      ST_QUAL: begin
        if (sample == cand_q) begin
          if (qual_inc == QUAL_TARGET) begin
            commit      = 1'b1;
            commit_pair = cand_q;
            qual_nxt    = '0;
            state_nxt   = ST_STEADY;
          end else begin
            qual_nxt = qual_inc;
          end
        end else if (sample == cp_q) begin
          // Glitch back to the committed pair: abandon the candidate silently.
          qual_nxt  = '0;
          state_nxt = ST_STEADY;
        end else begin
          cand_nxt = sample;
          qual_nxt = QUAL_ONE;
        end
      end

      default: begin
        qual_nxt  = '0;
        state_nxt = ST_STEADY;
      end
    endcase
  end

  // Commit effects: O only follows valid pairs, so it holds through invalid periods.
  always_comb begin
    cp_nxt      = cp_q;
    o_nxt       = o;
    invalid_nxt = invalid;
    err_event   = 1'b0;
    if (commit) begin
      cp_nxt    = commit_pair;
      err_event = is_valid_pair(cp_q) && !is_valid_pair(commit_pair);
      if (is_valid_pair(commit_pair)) begin
        o_nxt       = commit_pair[1];
        invalid_nxt = 1'b0;
      end else begin
        invalid_nxt = 1'b1;
      end
    end
  end

  // Clear has priority over a coincident increment; the counter sticks at all-ones.
  always_comb begin
    cnt_nxt = err_cnt;
    if (cnt_clr) begin
      cnt_nxt = '0;
    end else if (err_event && (err_cnt != '1)) begin
      cnt_nxt = err_cnt + CNT_W'(1);
    end
  end

  // NOTE: every flop here is reset, including candidate and count, so a reset mid-qualification leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STEADY;
      cp_q    <= PAIR_ZERO;
      cand_q  <= PAIR_ZERO;
      qual_q  <= '0;
      o       <= 1'b0;
      invalid <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      cp_q    <= cp_nxt;
      cand_q  <= cand_nxt;
      qual_q  <= qual_nxt;
      o       <= o_nxt;
      invalid <= invalid_nxt;
      err_cnt <= cnt_nxt;
    end
  end

`ifdef IBUFDS_RX_EDGE_EN
  logic o_dly;

  // Pulses trail the O change by one cycle; reset clears both copies so no pulse follows it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_dly <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      o_dly <= o;
      rise  <= o & ~o_dly;
      fall  <= ~o & o_dly;
    end
  end
`endif

endmodule

// File: rtl/ibufds_rx_filter.sv
// Multi-channel filtered differential receiver: WIDTH independent ibufds_rx_chan instances.
// Define IBUFDS_RX_EDGE_EN to add the rise/fall pulse outputs.
module ibufds_rx_filter
  import ibufds_rx_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       I,
  input  logic [WIDTH-1:0]       IB,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       O,
  output logic [WIDTH-1:0]       invalid,
  output logic [WIDTH*CNT_W-1:0] err_cnt
`ifdef IBUFDS_RX_EDGE_EN
  ,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall
`endif
);

  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
    ibufds_rx_chan #(
      .FILT_LEN (FILT_LEN),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .i       (I[ch]),
      .ib      (IB[ch]),
      .cnt_clr (cnt_clr),
      .o       (O[ch]),
      .invalid (invalid[ch]),
      .err_cnt (err_cnt[ch*CNT_W +: CNT_W])
`ifdef IBUFDS_RX_EDGE_EN
      ,
      .rise    (rise[ch]),
      .fall    (fall[ch])
`endif
    );
  end

endmodule

// File: tb/tb_ibufds_rx_filter.sv
// Scoreboard bench for ibufds_rx_filter: a run-length reference model predicts every cycle,
// a monitor compares on the falling edge, and directed checks cover latency, glitch, saturation and reset.
`timescale 1ns/1ps
module tb_ibufds_rx_filter;

  localparam int WIDTH    = 8;
  localparam int FILT_LEN = 4;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [WIDTH-1:0]       I;
  logic [WIDTH-1:0]       IB;
  logic                   cnt_clr;
  logic [WIDTH-1:0]       O;
  logic [WIDTH-1:0]       invalid;
  logic [WIDTH*CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0]       rise_act;
  logic [WIDTH-1:0]       fall_act;

  ibufds_rx_filter #(
    .WIDTH    (WIDTH),
    .FILT_LEN (FILT_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .I       (I),
    .IB      (IB),
    .cnt_clr (cnt_clr),
    .O       (O),
    .invalid (invalid),
    .err_cnt (err_cnt)
`ifdef IBUFDS_RX_EDGE_EN
    ,
    .rise    (rise_act),
    .fall    (fall_act)
`endif
  );

`ifndef IBUFDS_RX_EDGE_EN
  assign rise_act = '0;
  assign fall_act = '0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0]       o;
    logic [WIDTH-1:0]       inv;
    logic [WIDTH-1:0]       rise;
    logic [WIDTH-1:0]       fall;
    logic [WIDTH*CNT_W-1:0] cnt;
  } obs_t;

  typedef struct packed {
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] ib;
  } pads_t;

  obs_t  sb_q[$];
  pads_t pad_hist[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state, per channel.
  logic [1:0] m_cp      [WIDTH];
  logic [1:0] m_run_val [WIDTH];
  int         m_run_len [WIDTH];
  logic       m_o       [WIDTH];
  logic       m_o_prev  [WIDTH];
  logic       m_inv     [WIDTH];
  int         m_cnt     [WIDTH];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pair_ok(input logic [1:0] p);
    return (p == 2'b10) || (p == 2'b01);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return err_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic model_reset();
    pad_hist.delete();
    pad_hist.push_back('0);
    pad_hist.push_back('0);
    for (int ch = 0; ch < WIDTH; ch++) begin
      m_cp[ch]      = 2'b01;
      m_run_val[ch] = 2'b00;
      m_run_len[ch] = 0;
      m_o[ch]       = 1'b0;
      m_o_prev[ch]  = 1'b0;
      m_inv[ch]     = 1'b0;
      m_cnt[ch]     = 0;
    end
  endtask

  // One clock edge: the pads reach the filter two edges late; a pair commits once it has been
  // seen FILT_LEN times in a row and differs from the committed pair.
  task automatic model_step(output obs_t e);
    pads_t      cur;
    logic [1:0] s;
    logic       bump;
    logic       o_old;
    pad_hist.push_back('{i: I, ib: IB});
    cur = pad_hist.pop_front();
    e   = '0;
    for (int ch = 0; ch < WIDTH; ch++) begin
      s = {cur.i[ch], cur.ib[ch]};
      if (m_run_len[ch] > 0 && s == m_run_val[ch]) m_run_len[ch]++;
      else begin
        m_run_val[ch] = s;
        m_run_len[ch] = 1;
      end
      o_old = m_o[ch];
      bump  = 1'b0;
      if (s != m_cp[ch] && m_run_len[ch] == FILT_LEN) begin
        bump     = pair_ok(m_cp[ch]) && !pair_ok(s);
        m_cp[ch] = s;
        if (pair_ok(s)) begin
          m_o[ch]   = s[1];
          m_inv[ch] = 1'b0;
        end else begin
          m_inv[ch] = 1'b1;
        end
      end
      if (cnt_clr) m_cnt[ch] = 0;
      else if (bump && m_cnt[ch] < CNT_MAX) m_cnt[ch]++;
`ifdef IBUFDS_RX_EDGE_EN
      e.rise[ch] = o_old & ~m_o_prev[ch];
      e.fall[ch] = ~o_old & m_o_prev[ch];
`endif
      m_o_prev[ch] = o_old;
      e.o[ch]      = m_o[ch];
      e.inv[ch]    = m_inv[ch];
      e.cnt[ch*CNT_W +: CNT_W] = CNT_W'(m_cnt[ch]);
    end
  endtask

  // Predictor: inputs only change on the falling edge, so they are stable here.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        model_reset();
        sb_q.push_back('0);
      end else begin
        model_step(e);
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: compares one prediction per cycle, half a period after the edge.
  initial begin
    obs_t exp_v;
    obs_t act_v;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        act_v = '{o: O, inv: invalid, rise: rise_act, fall: fall_act, cnt: err_cnt};
        check("scoreboard", act_v, exp_v);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int ch, input logic [1:0] p);
    I[ch]  = p[1];
    IB[ch] = p[0];
  endtask

  initial begin
    logic [1:0] p;
    int         rise_n;
    int         fall_n;
    I       = '0;
    IB      = '1;
    cnt_clr = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_O", O, 0);
    check("reset_invalid", invalid, 0);
    check("reset_cnt", err_cnt, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (8) @(negedge clk);

    // Latency: the capture edge counts as the first of FILT_LEN+2 edges.
    drive(0, 2'b10);
    for (int n = 1; n <= FILT_LEN + 2; n++) begin
      @(posedge clk);
      #1;
      if (n == FILT_LEN + 1) check("latency_before", O[0], 0);
    end
    check("latency_O", O[0], 1);
    check("latency_invalid", invalid[0], 0);
    check("latency_cnt", cnt_of(0), 0);

    // Short glitch to 01 must be rejected.
    @(negedge clk) drive(0, 2'b01);
    repeat (3) @(negedge clk);
    drive(0, 2'b10);
    repeat (12) @(negedge clk);
    check("glitch_O", O[0], 1);
    check("glitch_invalid", invalid[0], 0);
    check("glitch_cnt", cnt_of(0), 0);

    // Invalid 11 holds O, flags invalid and counts once; 00 afterwards does not count.
    drive(0, 2'b11);
    repeat (10) @(negedge clk);
    check("inv11_invalid", invalid[0], 1);
    check("inv11_O", O[0], 1);
    check("inv11_cnt", cnt_of(0), 1);
    drive(0, 2'b00);
    repeat (10) @(negedge clk);
    check("inv00_cnt", cnt_of(0), 1);
    check("inv00_invalid", invalid[0], 1);
    drive(0, 2'b01);
    repeat (10) @(negedge clk);
    check("back01_O", O[0], 0);
    check("back01_invalid", invalid[0], 0);

    // Saturation on channel 2.
    for (int k = 0; k < 300; k++) begin
      drive(2, 2'b10);
      repeat (6) @(negedge clk);
      drive(2, 2'b11);
      repeat (6) @(negedge clk);
    end
    check("sat_cnt", cnt_of(2), CNT_MAX);
    drive(2, 2'b10);
    repeat (6) @(negedge clk);
    drive(2, 2'b11);
    repeat (FILT_LEN + 1) @(posedge clk);
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;
    check("clr_wins_cnt", cnt_of(2), 0);
    check("clr_wins_invalid", invalid[2], 1);

    // Toggling every cycle never commits.
    for (int k = 0; k < 40; k++) begin
      drive(7, (k % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    drive(7, 2'b01);
    repeat (8) @(negedge clk);
    check("toggle_O", O[7], 0);
    check("toggle_invalid", invalid[7], 0);

    // Edge pulses on channel 5: one rise then one fall.
    rise_n = 0;
    fall_n = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 0)  drive(5, 2'b10);
      if (k == 12) drive(5, 2'b01);
      @(negedge clk);
      rise_n += int'(rise_act[5]);
      fall_n += int'(fall_act[5]);
    end
`ifdef IBUFDS_RX_EDGE_EN
    check("edge_rise_count", rise_n, 1);
    check("edge_fall_count", fall_n, 1);
`else
    check("edge_rise_absent", rise_n, 0);
`endif

    // Randomised traffic with occasional counter clears.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < WIDTH; ch++) begin
        if ($urandom_range(0, 5) == 0) begin
          p = 2'($urandom_range(0, 3));
          drive(ch, p);
        end
      end
      cnt_clr = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk) cnt_clr = 1'b0;

    // Asynchronous reset while channels are qualifying a new pair.
    I  = '1;
    IB = '0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_O", O, 0);
    check("async_reset_invalid", invalid, 0);
    check("async_reset_cnt", err_cnt, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    for (int n = 1; n <= FILT_LEN + 2; n++) begin
      @(posedge clk);
      #1;
      if (n == FILT_LEN + 1) check("release_before", O, 0);
    end
    check("release_O", O, {WIDTH{1'b1}});
    check("release_invalid", invalid, 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibufds_rx_filter.md
Name: ibufds_rx_filter

Overview:
- Multi-channel differential input receiver for clocked fabric logic.
- Per channel it synchronises the I/IB pair, classifies each sample as valid (10 or 01) or invalid (00 or 11), and requires a new state to be stable before committing it.
- O holds the last valid value while the pair is invalid; a filtered invalid flag and a saturating invalid-event counter are reported.
- Sits directly behind the IBUFDS-family pad buffers, feeding clean data into PicoBlaze I/O ports.

Parameters:
- WIDTH, 8, number of differential channels.
- FILT_LEN, 4, consecutive identical synchronised samples required to commit a state; legal range 1..255.
- CNT_W, 8, width of each per-channel invalid-event counter.

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- I  input  WIDTH  true side of each pair; asynchronous to clk.
- IB  input  WIDTH  complement side of each pair; asynchronous to clk.
- cnt_clr  input  1  synchronous clear of all counters.
- O  output  WIDTH  filtered data.
- invalid  output  WIDTH  committed state is 00 or 11.
- err_cnt  output  WIDTH*CNT_W  per-channel counters; channel n occupies bits [n*CNT_W +: CNT_W].

Behaviour:
- Reset (asynchronous assert, synchronous release by design convention):
  - O=0, invalid=0, err_cnt=0.
  - Synchroniser flops=0; committed pair=2'b01; FSM in ST_STEADY; qualification count=0.
- Synchroniser: two flop stages per pair bit. s = {I,IB} after stage 2.
- FSM per channel, states ST_STEADY and ST_QUAL. Registers: committed pair cp, candidate cand, counter q (8 bits).
- ST_STEADY:
  - If s==cp, remain.
  - Else cand<=s, q<=1, go to ST_QUAL.
  - If FILT_LEN==1, commit in the same cycle instead and stay in ST_STEADY.
- ST_QUAL:
  - s==cand: q<=q+1. When q+1==FILT_LEN, commit cand and go to ST_STEADY.
  - s==cp (glitch back): go to ST_STEADY; nothing committed.
  - Otherwise: cand<=s, q<=1, remain in ST_QUAL.
- Commit of pair p:
  - cp<=p.
  - p valid (10 or 01): O<=p[1] and invalid<=0.
  - p invalid: O unchanged and invalid<=1.
- Latency: a pad change that is stable is visible on O/invalid exactly FILT_LEN+2 clk edges after the first edge that captures it in stage 1.
- Counter:
  - Increments by 1 on every commit transitioning from a valid cp to an invalid pair.
  - Invalid-to-invalid commits (00 to 11) do not count.
  - Saturates at all-ones; no wrap.
  - cnt_clr zeroes all counters next edge.
  - cnt_clr coincident with an increment: clear wins, result 0.
- Channels are fully independent; simultaneous events on different channels need no arbitration.
- Reset mid-qualification discards cand/q; reset overrides all.
- Inputs toggling every cycle with FILT_LEN>1 never commit: O holds indefinitely.

Optional Feature:
- Macro IBUFDS_RX_EDGE_EN.
- Defined:
  - Adds outputs rise and fall, each WIDTH bits.
  - Each is a one-cycle pulse in the cycle after O changes 0→1 or 1→0 respectively.
  - No pulse from reset, invalid commits, or cnt_clr.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ibufds_rx_pkg holds:
  - State enum (ST_STEADY, ST_QUAL).
  - Pair localparams PAIR_ONE=2'b10, PAIR_ZERO=2'b01, PAIR_LO=2'b00, PAIR_HI=2'b11.
  - Function is_valid_pair.
- Sub-module ibufds_rx_chan implements one channel (synchroniser, FSM, counter, optional edge logic). The top generates WIDTH instances and concatenates err_cnt.

Test Plan:
- Reset then I=1,IB=0 held on ch0, FILT_LEN=4 → O[0]=1 exactly 6 edges after capture; invalid[0]=0; err_cnt ch0=0.
- After ch0 commits 1, drive a 3-cycle glitch to 0/1 (FILT_LEN=4) → O[0] stays 1, FSM returns to ST_STEADY, no counter change.
- After ch0 commits 1, drive I=IB=1 for 10 cycles → invalid[0]=1 after 6 edges, O[0] stays 1, err_cnt ch0=1. Then drive 00 stable → still 1. Then drive 01 → O[0]=0, invalid[0]=0.
- 300 valid→invalid events on ch2 with CNT_W=8 → err_cnt ch2=255. Assert cnt_clr on the same edge as a 301st increment → 0.
- Assert reset_n low mid-qualification → all outputs 0 immediately (asynchronous). Release with pair 10 stable → O=1 after FILT_LEN+2 edges.
- With IBUFDS_RX_EDGE_EN defined, toggle ch5 0→1→0 with stable periods → exactly one rise pulse and one fall pulse, each 1 cycle wide, one cycle after O changes.
